// File: rtl/common_types_pkg.sv
// common_types_pkg: shared AHB transfer types, frontend states and timer register map
package common_types_pkg;
    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;
    typedef enum logic [1:0] {
        FE_IDLE,
        FE_ERR1,
        FE_ERR2
    } fe_state_t;
    localparam logic [7:0] TMR_CTRL   = 8'h00;
    localparam logic [7:0] TMR_PRESC  = 8'h04;
    localparam logic [7:0] TMR_COUNT  = 8'h08;
    localparam logic [7:0] TMR_CMP    = 8'h0C;
    localparam logic [7:0] TMR_STATUS = 8'h10;
    typedef struct packed {
        logic auto_rld;
        logic ie;
        logic en;
    } tmr_ctrl_t;
endpackage

// File: rtl/ahb_slave_frontend.sv
// ahb_slave_frontend: AHB-lite address-phase latch, transfer legality check and two-cycle ERROR response
module ahb_slave_frontend
    import common_types_pkg::*;
#(
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 hsel,
    input  logic [31:0]          haddr,
    input  logic [1:0]           htrans,
    input  logic                 hwrite,
    input  logic [2:0]           hsize,
    input  logic [31:0]          hwdata,
    output logic                 hready,
    output logic                 hresp,
    output logic                 wr_en,
    output logic                 rd_en,
    output logic [ADDR_BITS-1:0] offset,
    output logic [31:0]          wdata
);
    fe_state_t state_q, state_d;
    logic valid_q, valid_d, write_q, write_d;
    logic [ADDR_BITS-1:0] offset_q, offset_d;
    logic accept, legal, unused_hi;
    htrans_t ht;
    assign ht = htrans_t'(htrans);
    assign hready = state_q != FE_ERR1;
    assign hresp = state_q != FE_IDLE;
    assign accept = hsel && (ht == HT_NONSEQ || ht == HT_SEQ) && hready;
    assign legal = hsize == 3'b010 && haddr[1:0] == 2'b00;
    assign unused_hi = ^haddr[31:ADDR_BITS];
    always_comb begin
        valid_d = accept && legal;
        write_d = accept ? hwrite : write_q;
        offset_d = accept ? haddr[ADDR_BITS-1:0] : offset_q;
        state_d = state_q == FE_ERR1 ? FE_ERR2 : (accept && !legal) ? FE_ERR1 : FE_IDLE;
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= FE_IDLE;
            valid_q <= 1'b0;
            write_q <= 1'b0;
            offset_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            write_q <= write_d;
            offset_q <= offset_d;
        end
    end
    assign wr_en = valid_q && write_q;
    assign rd_en = valid_q && !write_q;
    assign offset = offset_q;
    assign wdata = hwdata;
endmodule

// File: rtl/ahb_timer_slave.sv
// ahb_timer_slave: AHB-lite timer with 32-bit up-counter, prescaler and compare-match level interrupt
module ahb_timer_slave
    import common_types_pkg::*;
#(
    parameter int PRESC_W   = 16,
    parameter int ADDR_BITS = 5
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp,
    output logic        tmr_int
);
    logic wr_en, rd_en;
    logic [ADDR_BITS-1:0] offset;
    logic [31:0] wdata;
    tmr_ctrl_t ctrl_q, ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d, presc_cnt_q, presc_cnt_d;
    logic [31:0] count_q, count_d, cmp_q, cmp_d;
    logic match_q, match_d;
    logic tick, hit;
    logic wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
    ahb_slave_frontend #(.ADDR_BITS(ADDR_BITS)) u_fe (
        .clk(clk), .nrst(nrst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready), .hresp(hresp),
        .wr_en(wr_en), .rd_en(rd_en), .offset(offset), .wdata(wdata)
    );
    assign wr_ctrl = wr_en && offset == TMR_CTRL[ADDR_BITS-1:0];
    assign wr_presc = wr_en && offset == TMR_PRESC[ADDR_BITS-1:0];
    assign wr_count = wr_en && offset == TMR_COUNT[ADDR_BITS-1:0];
    assign wr_cmp = wr_en && offset == TMR_CMP[ADDR_BITS-1:0];
    assign wr_status = wr_en && offset == TMR_STATUS[ADDR_BITS-1:0];
    // a bus write to COUNT swallows a coincident tick, including its match
    always_comb begin
        tick = ctrl_q.en && presc_cnt_q == presc_q;
        hit = tick && !wr_count && count_q == cmp_q;
        ctrl_d = wr_ctrl ? tmr_ctrl_t'(wdata[2:0]) : ctrl_q;
        presc_d = wr_presc ? wdata[PRESC_W-1:0] : presc_q;
        presc_cnt_d = (wr_presc || tick) ? '0 : ctrl_q.en ? presc_cnt_q + PRESC_W'(1) : presc_cnt_q;
        cmp_d = wr_cmp ? wdata : cmp_q;
        count_d = wr_count ? wdata : !tick ? count_q : (hit && ctrl_q.auto_rld) ? 32'd0 : count_q + 32'd1;
        match_d = hit || (match_q && !(wr_status && wdata[0]));
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ctrl_q <= '0;
            presc_q <= '0;
            presc_cnt_q <= '0;
            count_q <= '0;
            cmp_q <= '1;
            match_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            presc_q <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            count_q <= count_d;
            cmp_q <= cmp_d;
            match_q <= match_d;
        end
    end
    assign hrdata = !rd_en ? 32'd0
        : offset == TMR_CTRL[ADDR_BITS-1:0] ? {29'd0, ctrl_q}
        : offset == TMR_PRESC[ADDR_BITS-1:0] ? 32'(presc_q)
        : offset == TMR_COUNT[ADDR_BITS-1:0] ? count_q
        : offset == TMR_CMP[ADDR_BITS-1:0] ? cmp_q
        : offset == TMR_STATUS[ADDR_BITS-1:0] ? {31'd0, match_q}
        : 32'd0;
    assign tmr_int = match_q && ctrl_q.ie;
endmodule

// File: tb/tb_ahb_timer_slave.sv
// tb_ahb_timer_slave: table-driven and scoreboard-checked AHB bench for the timer slave
module tb_ahb_timer_slave;
    logic clk = 1'b0, nrst = 1'b0, hsel, hwrite, hready, hresp, tmr_int;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0] htrans;
    logic [2:0] hsize;
    int cyc = 0, n_chk = 0, n_err = 0, k;
    int m_c0, m_presc, m_mod;
    logic [31:0] m_base;
    logic [31:0] sb[$];
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[10];

    ahb_timer_slave dut (
        .clk(clk), .nrst(nrst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp), .tmr_int(tmr_int)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_bus();
        hsel = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr = 32'd0;
        hsize = 3'b010;
    endtask

    task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel = 1'b1;
        htrans = 2'b10;
        haddr = a;
        hwrite = w;
        hsize = sz;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_ph(a, 1'b1, 3'b010);
        @(posedge clk); #1;
        idle_bus();
        hwdata = d;
        @(negedge clk);
        chk("wr_hresp", {31'd0, hresp}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic rd_check(input logic [31:0] a, input logic [31:0] exp, input string nm);
        addr_ph(a, 1'b0, 3'b010);
        sb.push_back(exp);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        chk(nm, hrdata, sb.pop_front());
        @(posedge clk); #1;
    endtask

    // expected COUNT after edge c, for a counter started at edge m_c0
    function automatic logic [31:0] exp_count(input int c);
        int steps;
        steps = (c - m_c0) / (m_presc + 1);
        return (m_mod != 0) ? 32'(steps % m_mod) : m_base + 32'(steps);
    endfunction

    task automatic cnt_burst(input int n, input string nm);
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                addr_ph(32'h8, 1'b0, 3'b010);
                sb.push_back(exp_count(cyc + 1));
            end else idle_bus();
            if (i > 0) begin
                @(negedge clk);
                chk($sformatf("%s_%0d", nm, i), hrdata, sb.pop_front());
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic start_cnt(input logic [31:0] base, input int presc, input int md);
        m_c0 = cyc;
        m_base = base;
        m_presc = presc;
        m_mod = md;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 32'h00, 32'hFFFF_FFF6, 32'h6};
        vecs[1] = '{1'b1, 32'h04, 32'hABCD_1234, 32'h1234};
        vecs[2] = '{1'b1, 32'h08, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 32'h0C, 32'h1234_5678, 32'h1234_5678};
        vecs[4] = '{1'b1, 32'h10, 32'hFFFF_FFFF, 32'h0};
        vecs[5] = '{1'b1, 32'h14, 32'hFFFF_FFFF, 32'h0};
        vecs[6] = '{1'b1, 32'h18, 32'h5A5A_5A5A, 32'h0};
        vecs[7] = '{1'b1, 32'h1C, 32'h0000_0001, 32'h0};
        vecs[8] = '{1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF};
        vecs[9] = '{1'b1, 32'h4000_000C, 32'hCAFE_F00D, 32'hCAFE_F00D};
        idle_bus();
        hwdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hready", {31'd0, hready}, 32'd1);
        chk("rst_hresp", {31'd0, hresp}, 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_tmr_int", {31'd0, tmr_int}, 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
            rd_check(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        addr_ph(32'h8, 1'b1, 3'b010);
        @(posedge clk); #1;
        idle_bus();
        hwdata = 32'h55;
        #1 nrst = 1'b0;
        @(negedge clk);
        chk("midrst_hready", {31'd0, hready}, 32'd1);
        chk("midrst_hresp", {31'd0, hresp}, 32'd0);
        chk("midrst_hrdata", hrdata, 32'd0);
        chk("midrst_tmr_int", {31'd0, tmr_int}, 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        rd_check(32'h08, 32'h0, "midrst_count");
        rd_check(32'h0C, 32'hFFFF_FFFF, "midrst_cmp");
        rd_check(32'h00, 32'h0, "midrst_ctrl");
        rd_check(32'h04, 32'h0, "midrst_presc");

        wr(32'h04, 32'd3);
        wr(32'h0C, 32'd5);
        wr(32'h00, 32'd3);
        start_cnt(32'd0, 3, 0);
        cnt_burst(14, "t2_count");
        @(negedge clk);
        chk("t2_hrdata_idle", hrdata, 32'd0);
        k = -1;
        for (int i = 0; i < 40 && k < 0; i++) begin
            @(negedge clk);
            if (tmr_int) k = cyc - m_c0;
        end
        chk("t2_int_rise", k, 32'd24);
        @(posedge clk); #1;
        rd_check(32'h10, 32'h1, "t2_match");
        wr(32'h10, 32'h1);
        @(negedge clk);
        chk("t2_int_clear", {31'd0, tmr_int}, 32'd0);
        @(posedge clk); #1;

        wr(32'h00, 32'd0);
        wr(32'h08, 32'd0);
        wr(32'h04, 32'd0);
        wr(32'h0C, 32'd2);
        wr(32'h10, 32'd1);
        wr(32'h00, 32'd7);
        start_cnt(32'd0, 0, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t3_int_%0d", i), {31'd0, tmr_int}, (i == 3) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        cnt_burst(6, "t3_count");
        wr(32'h10, 32'd1);
        k = -1;
        for (int i = 0; i < 6 && k < 0; i++) begin
            @(negedge clk);
            if (tmr_int) k = 1;
        end
        chk("t3_match_again", k, 32'd1);
        @(posedge clk); #1;

        wr(32'h00, 32'd0);
        wr(32'h08, 32'hFFFF_FFFE);
        wr(32'h0C, 32'd10);
        wr(32'h04, 32'd0);
        wr(32'h10, 32'd1);
        wr(32'h00, 32'd1);
        start_cnt(32'hFFFF_FFFE, 0, 0);
        cnt_burst(3, "t4_count");
        rd_check(32'h10, 32'h0, "t4_status");
        wr(32'h00, 32'd0);

        wr(32'h08, 32'h1234);
        addr_ph(32'h8, 1'b1, 3'b001);
        @(posedge clk); #1;
        idle_bus();
        hwdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("e1_err1_hready", {31'd0, hready}, 32'd0);
        chk("e1_err1_hresp", {31'd0, hresp}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("e1_err2_hready", {31'd0, hready}, 32'd1);
        chk("e1_err2_hresp", {31'd0, hresp}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("e1_after_hresp", {31'd0, hresp}, 32'd0);
        @(posedge clk); #1;
        rd_check(32'h08, 32'h1234, "e1_count");
        addr_ph(32'hA, 1'b0, 3'b010);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        chk("e2_err1_hready", {31'd0, hready}, 32'd0);
        chk("e2_err1_hresp", {31'd0, hresp}, 32'd1);
        chk("e2_err1_hrdata", hrdata, 32'd0);
        @(posedge clk); #1;
        addr_ph(32'h8, 1'b0, 3'b010);
        sb.push_back(32'h1234);
        @(negedge clk);
        chk("e2_err2_hready", {31'd0, hready}, 32'd1);
        chk("e2_err2_hresp", {31'd0, hresp}, 32'd1);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        chk("e2_b2b_hrdata", hrdata, sb.pop_front());
        chk("e2_b2b_hresp", {31'd0, hresp}, 32'd0);
        chk("e2_b2b_hready", {31'd0, hready}, 32'd1);
        @(posedge clk); #1;
        hsel = 1'b1;
        htrans = 2'b01;
        haddr = 32'h8;
        hwrite = 1'b1;
        @(posedge clk); #1;
        idle_bus();
        hwdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("busy_hresp", {31'd0, hresp}, 32'd0);
        @(posedge clk); #1;
        rd_check(32'h08, 32'h1234, "busy_count");

        wr(32'h00, 32'd0);
        wr(32'h08, 32'd0);
        wr(32'h0C, 32'hFFFF_FFFF);
        wr(32'h04, 32'd1);
        wr(32'h00, 32'd1);
        start_cnt(32'd0, 1, 0);
        if ((cyc - m_c0) % 2 != 0) begin
            @(posedge clk); #1;
        end
        wr(32'h08, 32'h100);
        rd_check(32'h08, 32'h100, "t6_count_collide");

        wr(32'h00, 32'd0);
        wr(32'h08, 32'd0);
        wr(32'h04, 32'd0);
        wr(32'h0C, 32'd2);
        wr(32'h10, 32'd1);
        wr(32'h00, 32'd7);
        start_cnt(32'd0, 0, 3);
        for (int i = 0; i < 8 && ((cyc + 2 - m_c0) % 3 != 1 || cyc - m_c0 < 3); i++) begin
            @(posedge clk); #1;
        end
        wr(32'h10, 32'd1);
        rd_check(32'h10, 32'h0, "t6_w1c_clear");
        for (int i = 0; i < 4 && (cyc + 2 - m_c0) % 3 != 0; i++) begin
            @(posedge clk); #1;
        end
        wr(32'h10, 32'd1);
        rd_check(32'h10, 32'h1, "t6_w1c_vs_set");
        @(negedge clk);
        chk("t6_tmr_int", {31'd0, tmr_int}, 32'd1);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
